mmio_responder: RTL and testbench

//  Responder end of the CPU IO strobes: accepts io_read/io_write for any address whose upper bits the decoder

---
 rtl/mmio_responder.sv | 173 +++++++++++++++++
 tb/tb_mmio_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// IO-region responder: a four-state handshake FSM in front of a small register file
// holding switches, LEDs, a seven-seg value and a cycle timer with compare.
//
// state   | meaning
// IDLE    | capture strobes, offset and store data every cycle
// ACCESS  | decode the held offset, perform the write or load io_rdata
// ACK     | io_ready (and io_err if flagged) for exactly one cycle
// RELEASE | wait for both strobes low so a held strobe cannot retrigger
module mmio_responder #(
   parameter int ADDR_W      = 10,
   parameter int SW_W        = 24,
   parameter int LED_W       = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              io_read,
   input  logic              io_write,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [31:0]       io_wdata,
   output logic [31:0]       io_rdata,
   output logic              io_ready,
   output logic              io_err,
   input  logic [SW_W-1:0]   sw_in,
   output logic [LED_W-1:0]  led_out,
   output logic [31:0]       seg_out,
   output logic              timer_hit
);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK, RELEASE} state_t;

   localparam logic [ADDR_W-1:0] OFF_SW    = ADDR_W'('h000);
   localparam logic [ADDR_W-1:0] OFF_LED   = ADDR_W'('h060);
   localparam logic [ADDR_W-1:0] OFF_SEG   = ADDR_W'('h070);
   localparam logic [ADDR_W-1:0] OFF_TCNT  = ADDR_W'('h080);
   localparam logic [ADDR_W-1:0] OFF_TCTRL = ADDR_W'('h084);
   localparam logic [ADDR_W-1:0] OFF_TCMP  = ADDR_W'('h088);
   localparam logic [ADDR_W-1:0] OFF_TSTAT = ADDR_W'('h08C);

   state_t state;

   logic              rd_q, wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;

   logic [SW_W-1:0]   sw_sync_r [SYNC_STAGES];
   logic [SW_W-1:0]   sw_sync;

   logic [31:0]       tcnt;
   logic [31:0]       tcmp;
   logic              tc_en;

   logic [ADDR_W-1:0] off;
   logic              hit_map;
   logic [31:0]       rd_val;
   logic              do_wr, do_rd, both;
   logic              wr_tctrl, rd_tstat;

   assign sw_sync = sw_sync_r[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sw_sync_r[i] <= '0;
      end else begin
         sw_sync_r[0] <= sw_in;
         for (int i = 1; i < SYNC_STAGES; i++) sw_sync_r[i] <= sw_sync_r[i-1];
      end
   end

   always_comb begin
      off     = {addr_q[ADDR_W-1:2], 2'b00};
      hit_map = 1'b1;
      rd_val  = 32'h0;
      case (off)
         OFF_SW:    rd_val = 32'(sw_sync);
         OFF_LED:   rd_val = 32'(led_out);
         OFF_SEG:   rd_val = seg_out;
         OFF_TCNT:  rd_val = tcnt;
         OFF_TCTRL: rd_val = {31'h0, tc_en};
         OFF_TCMP:  rd_val = tcmp;
         OFF_TSTAT: rd_val = {31'h0, timer_hit};
         default: begin
            hit_map = 1'b0;
            rd_val  = 32'h0;
         end
      endcase
   end

   assign both     = rd_q & wr_q;
   assign do_wr    = (state == ACCESS) & wr_q & ~rd_q & hit_map;
   assign do_rd    = (state == ACCESS) & rd_q & ~wr_q;
   assign wr_tctrl = do_wr & (off == OFF_TCTRL);
   assign rd_tstat = do_rd & (off == OFF_TSTAT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         io_rdata <= 32'h0;
         io_ready <= 1'b0;
         io_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               io_ready <= 1'b0;
               io_err   <= 1'b0;
               rd_q     <= io_read;
               wr_q     <= io_write;
               addr_q   <= io_addr;
               wdata_q  <= io_wdata;
               if (io_read | io_write) state <= ACCESS;
            end
            ACCESS: begin
               if (do_rd) io_rdata <= rd_val;
               io_ready <= 1'b1;
               io_err   <= both | ~hit_map;
               state    <= ACK;
            end
            ACK: begin
               io_ready <= 1'b0;
               io_err   <= 1'b0;
               state    <= RELEASE;
            end
            default: begin
               io_ready <= 1'b0;
               io_err   <= 1'b0;
               if (!io_read && !io_write) state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_out <= '0;
         seg_out <= 32'h0;
         tcmp    <= 32'hFFFF_FFFF;
         tc_en   <= 1'b0;
      end else if (do_wr) begin
         case (off)
            OFF_LED:   led_out <= wdata_q[LED_W-1:0];
            OFF_SEG:   seg_out <= wdata_q;
            OFF_TCTRL: tc_en   <= wdata_q[0];
            OFF_TCMP:  tcmp    <= wdata_q;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt <= 32'h0;
      end else if (wr_tctrl && wdata_q[1]) begin
         tcnt <= 32'h0;
      end else if (tc_en) begin
         tcnt <= tcnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_hit <= 1'b0;
      end else if (tc_en && (tcnt == tcmp)) begin
         timer_hit <= 1'b1;
      end else if (rd_tstat) begin
         timer_hit <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: expected load data / error flags are queued
// as each access is driven and popped when io_ready appears.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_read, io_write;
  logic [9:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ready, io_err;
  logic [23:0] sw_in;
  logic [23:0] led_out;
  logic [31:0] seg_out;
  logic        timer_hit;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct packed {
    logic        chk;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mmio_responder dut (
    .clk(clk), .rst_n(rst_n), .io_read(io_read), .io_write(io_write),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .io_ready(io_ready), .io_err(io_err), .sw_in(sw_in), .led_out(led_out),
    .seg_out(seg_out), .timer_hit(timer_hit)
  );

  task automatic io_access(input logic rd, input logic wr, input logic [9:0] addr,
                           input logic [31:0] wdata, input logic chk,
                           input logic [31:0] exp_rd, input logic exp_err,
                           output logic [31:0] got);
    exp_t e;
    int   lat;
    sb.push_back({chk, exp_err, exp_rd});
    @(negedge clk);
    io_read = rd; io_write = wr; io_addr = addr; io_wdata = wdata;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!io_ready && lat < 20);
    e   = sb.pop_front();
    got = io_rdata;
    total++;
    if (io_ready !== 1'b1 || lat !== 2)
      $display("FAIL latency addr=%h got=%0d ready=%b exp=2", addr, lat, io_ready);
    else pass_cnt++;
    if (e.chk) begin
      total++;
      if (io_rdata !== e.rdata) $display("FAIL rdata addr=%h got=%h exp=%h", addr, io_rdata, e.rdata);
      else pass_cnt++;
    end
    total++;
    if (io_err !== e.err) $display("FAIL err addr=%h got=%b exp=%b", addr, io_err, e.err);
    else pass_cnt++;
    @(negedge clk);
    io_read = 1'b0; io_write = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] g;
    #1;
    total++;
    if ({io_ready, io_err, timer_hit} !== 3'b000 || io_rdata !== 32'h0 ||
        led_out !== 24'h0 || seg_out !== 32'h0)
      $display("FAIL reset_outputs got=%b/%h/%h/%h exp=0", {io_ready, io_err, timer_hit},
               io_rdata, led_out, seg_out);
    else pass_cnt++;
    io_access(1, 0, 10'h088, 0, 1, 32'hFFFF_FFFF, 0, g);
    io_access(1, 0, 10'h084, 0, 1, 32'h0, 0, g);
    io_access(1, 0, 10'h080, 0, 1, 32'h0, 0, g);
  endtask

  task automatic test_led_seg();
    logic [31:0] g;
    io_access(0, 1, 10'h060, 32'h00A5_5A5A, 0, 0, 0, g);
    total++;
    if (led_out !== 24'hA55A5A) $display("FAIL led_out got=%h exp=a55a5a", led_out);
    else pass_cnt++;
    io_access(1, 0, 10'h060, 0, 1, 32'h00A5_5A5A, 0, g);
    io_access(0, 1, 10'h072, 32'hDEAD_BEEF, 0, 0, 0, g);
    total++;
    if (seg_out !== 32'hDEAD_BEEF) $display("FAIL seg_out got=%h exp=deadbeef", seg_out);
    else pass_cnt++;
    io_access(1, 0, 10'h070, 0, 1, 32'hDEAD_BEEF, 0, g);
  endtask

  task automatic test_switches();
    logic [31:0] g;
    sw_in = 24'h123456;
    repeat (3) @(posedge clk);
    io_access(1, 0, 10'h000, 0, 1, 32'h0012_3456, 0, g);
    io_access(0, 1, 10'h000, 32'hFFFF_FFFF, 0, 0, 0, g);
    io_access(1, 0, 10'h001, 0, 1, 32'h0012_3456, 0, g);
  endtask

  task automatic test_errors();
    logic [31:0] g;
    io_access(1, 0, 10'h3F0, 0, 1, 32'h0, 1, g);
    io_access(0, 1, 10'h3F4, 32'h1234_5678, 0, 0, 1, g);
    io_access(1, 1, 10'h060, 32'h0000_00FF, 0, 0, 1, g);
    total++;
    if (led_out !== 24'hA55A5A) $display("FAIL both_no_write got=%h exp=a55a5a", led_out);
    else pass_cnt++;
    io_access(0, 1, 10'h080, 32'h5555_5555, 0, 0, 0, g);
    io_access(1, 0, 10'h080, 0, 1, 32'h0, 0, g);
  endtask

  task automatic test_timer();
    logic [31:0] g;
    int n;
    io_access(0, 1, 10'h088, 32'd10, 0, 0, 0, g);
    @(negedge clk);
    io_write = 1'b1; io_addr = 10'h084; io_wdata = 32'h1;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (io_ready !== 1'b1) $display("FAIL tctrl_ready got=%b exp=1", io_ready);
    else pass_cnt++;
    io_write = 1'b0;
    n = 0;
    while (!timer_hit && n < 30) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (timer_hit !== 1'b1 || n !== 11) $display("FAIL hit_delay got=%0d hit=%b exp=11", n, timer_hit);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    io_access(1, 0, 10'h084, 0, 1, 32'h1, 0, g);
    io_access(1, 0, 10'h08C, 0, 1, 32'h1, 0, g);
    io_access(1, 0, 10'h08C, 0, 1, 32'h0, 0, g);
  endtask

  task automatic test_wrap();
    logic [31:0] g;
    int n;
    io_access(0, 1, 10'h084, 32'h2, 0, 0, 0, g);
    io_access(1, 0, 10'h084, 0, 1, 32'h0, 0, g);
    io_access(1, 0, 10'h080, 0, 1, 32'h0, 0, g);
    io_access(0, 1, 10'h088, 32'h0, 0, 0, 0, g);
    @(negedge clk);
    force dut.tcnt = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    release dut.tcnt;
    io_access(0, 1, 10'h084, 32'h1, 0, 0, 0, g);
    n = 0;
    while (!timer_hit && n < 40) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (timer_hit !== 1'b1) $display("FAIL wrap_hit got=%b exp=1", timer_hit);
    else pass_cnt++;
    io_access(1, 0, 10'h080, 0, 0, 0, 0, g);
    total++;
    if (g == 32'h0 || g > 32'd63) $display("FAIL wrap_tcnt got=%h exp=01..3f", g);
    else pass_cnt++;
    io_access(1, 0, 10'h08C, 0, 1, 32'h1, 0, g);
    io_access(0, 1, 10'h084, 32'h2, 0, 0, 0, g);
  endtask

  task automatic test_back_to_back();
    logic [31:0] g;
    int pulses, errs;
    @(negedge clk);
    io_read = 1'b1; io_addr = 10'h060;
    pulses = 0; errs = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (io_ready) pulses++;
      if (io_err) errs++;
    end
    total++;
    if (pulses !== 1 || errs !== 0) $display("FAIL held_strobe got=%0d/%0d exp=1/0", pulses, errs);
    else pass_cnt++;
    @(negedge clk);
    io_read = 1'b0;
    repeat (2) @(posedge clk);
    io_access(1, 0, 10'h070, 0, 1, 32'hDEAD_BEEF, 0, g);
    io_access(1, 0, 10'h060, 0, 1, 32'h00A5_5A5A, 0, g);
  endtask

  task automatic test_reset_abort();
    logic [31:0] g;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    io_write = 1'b1; io_addr = 10'h060; io_wdata = 32'h0000_0077;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    io_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++;
    if (led_out !== 24'h0 || io_ready !== 1'b0) $display("FAIL reset_abort got=%h/%b exp=0/0", led_out, io_ready);
    else pass_cnt++;
    io_access(1, 0, 10'h060, 0, 1, 32'h0, 0, g);
  endtask

  initial begin
    rst_n = 1'b0; io_read = 1'b0; io_write = 1'b0; io_addr = '0; io_wdata = '0; sw_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    test_reset();
    test_led_seg();
    test_switches();
    test_errors();
    test_timer();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
